dvp_capture: RTL and testbench
==============================

// Module: dvp_capture
// PURPOSE
//  Camera-side writer for the video FIFO path. Samples an OV5640-style DVP bus
//  (vsync/href/8-bit data), packs byte pairs into RGB565 pixels and drives the
//  FIFO write stream fifo_data_out/_en plus fifo_data_vs. The LCD-side timing
//  block reads that stream; fifo_data_vs high resets the FIFO.
//  Also measures the captured frame size for status and debug.
// PARAMETERS
//  DATA_WIDTH   16  packed pixel width; must equal 2*IN_WIDTH
//  IN_WIDTH     8   DVP data bus width
//  SKIP_FRAMES  10  frames discarded after reset while the sensor settles (0 = none)
//  CNT_WIDTH    12  width of pixel/line counters; counters saturate at all-ones
// PORTS
//  rgb_clk          in   1           sensor pixel clock (PCLK); the only clock
//  rgb_rst_n        in   1           asynchronous active-low reset
//  cam_vsync        in   1           frame sync, active high (high = blanking)
//  cam_href         in   1           line valid, active high
//  cam_data         in   IN_WIDTH    DVP byte; high byte first within a pixel
//  fifo_data_out    out  DATA_WIDTH  packed pixel {byte0, byte1}
//  fifo_data_out_en out  1           1-cycle write strobe per pixel
//  fifo_data_vs     out  1           FIFO reset / frame sync to the reader
//  frame_width      out  CNT_WIDTH   pixels in the last line of the last full frame
//  frame_height     out  CNT_WIDTH   lines in the last full frame
//  frame_done       out  1           1-cycle pulse when width/height update
//  line_err         out  1           1-cycle pulse: line ended on an odd byte count
// BEHAVIOUR
//  Reset: every output 0, except fifo_data_vs = 1. Internal state: FSM=SKIP,
//   skip counter=0, byte phase=0, counters=0.
//  Input stage: cam_vsync/href/data are registered once (vs_r, href_r, data_r).
//   All edge detection uses the registered copy and the registered copy delayed
//   by one more cycle.
//  FSM:
//   SKIP   - count vsync rising edges; after SKIP_FRAMES edges go to WAIT.
//            SKIP_FRAMES=0 goes to WAIT on the first cycle out of reset.
//   WAIT   - on a vsync falling edge go to ACTIVE. A frame is never joined mid-way.
//   ACTIVE - capture pixels. On a vsync rising edge latch the counters, pulse
//            frame_done and stay in ACTIVE. If vsync rises while href_r=1, drop
//            that frame (no frame_done) and go to WAIT.
//  fifo_data_vs: registered; 1 in SKIP and WAIT, otherwise equal to vs_r.
//   The FIFO is therefore held in reset until the first valid frame starts.
//  Packing (ACTIVE, href_r=1):
//   - Phase 0: store data_r as the high byte.
//   - Phase 1: output {hi, data_r}, assert _en on the next edge, and increment
//     the line pixel count.
//   - Latency: 2 rgb_clk edges from cam_data sampling of the 2nd byte to _en=1.
//   - The phase clears on the href_r rising edge, so no stale byte carries across lines.
//  Line end (href_r falling edge):
//   - Line count increments; the line pixel count is copied to a width shadow.
//   - If the phase is 1, the half pixel is dropped and line_err pulses.
//  Frame start (vsync falling edge): line and pixel counts clear.
//   Registered frame_width/height change only with frame_done, and hold through
//   a dropped frame.
//  Counters saturate; they never wrap.
//  Simultaneous href falling edge and vsync rising edge: the line is counted
//   before the latch.
//  Reset asserted mid-frame: return to SKIP at once; the skip count restarts.
// STRUCTURE
//  Shared package video_pkg: FSM state encoding (SKIP/WAIT/ACTIVE) and default
//  counter width, reused by the timing generator.
//  One natural sub-module: dvp_edge_sync (input register plus rise/fall detect
//  for vsync and href).
//  Packing, counters and FSM stay in this file.
// TESTING
//  1. SKIP_FRAMES=2, 3 frames of 4 lines x 8 bytes -> no _en in frames 1-2;
//     frame 3 gives 16 strobes, frame_done with width=4, height=4.
//  2. Bytes 0x12,0x34 -> fifo_data_out=0x1234 with _en exactly 2 edges after
//     0x34 is sampled.
//  3. Line of 7 bytes -> 3 strobes, line_err pulse, the next line starts at
//     phase 0 (first pixel correct).
//  4. Reset released mid-frame, SKIP_FRAMES=0 -> fifo_data_vs stays 1 and no
//     _en until the next vsync falling edge.
//  5. vsync rises while href=1 -> no frame_done, previous width/height held,
//     the next full frame captures normally.
//  6. CNT_WIDTH=4, 20-pixel line -> frame_width=15 (saturated), no wrap.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the camera capture and LCD timing paths.
// Holds the capture FSM encoding and the default counter width.
package video_pkg;

    typedef enum logic [1:0] {
        StSkip,
        StWait,
        StActive
    } cap_state_e;

    localparam int unsigned DefaultCntWidth = 12;

endpackage

// File: rtl/dvp_capture_if.sv
// DVP sensor bus in, packed FIFO write stream out.
// master = capture block, slave = sensor/FIFO side.
interface dvp_capture_if #(
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cam_vsync;
    logic                  cam_href;
    logic [IN_WIDTH-1:0]   cam_data;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_data_out_en;
    logic                  fifo_data_vs;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output fifo_data_out, fifo_data_out_en, fifo_data_vs
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  fifo_data_out, fifo_data_out_en, fifo_data_vs
    );
endinterface

// File: rtl/dvp_capture_edge_sync.sv
// Registers the DVP inputs once and derives vsync/href edges from the
// registered copy and a one-cycle-older copy.
module dvp_edge_sync #(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                rgb_clk,
    input  logic                rgb_rst_n,
    input  logic                vsync,
    input  logic                href,
    input  logic [IN_WIDTH-1:0] data,
    output logic                vs_r,
    output logic                href_r,
    output logic [IN_WIDTH-1:0] data_r,
    output logic                vs_rise,
    output logic                vs_fall,
    output logic                href_rise,
    output logic                href_fall
);
    logic vs_d;
    logic href_d;

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            vs_r   <= 1'b0;
            href_r <= 1'b0;
            data_r <= '0;
            vs_d   <= 1'b0;
            href_d <= 1'b0;
        end else begin
            vs_r   <= vsync;
            href_r <= href;
            data_r <= data;
            vs_d   <= vs_r;
            href_d <= href_r;
        end
    end

    assign vs_rise   = vs_r & ~vs_d;
    assign vs_fall   = ~vs_r & vs_d;
    assign href_rise = href_r & ~href_d;
    assign href_fall = ~href_r & href_d;
endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: packs byte pairs into pixels for the video FIFO and
// measures the size of each completed frame.
module dvp_capture
    import video_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IN_WIDTH    = 8,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned CNT_WIDTH   = DefaultCntWidth
) (
    input  logic                 rgb_clk,
    input  logic                 rgb_rst_n,
    dvp_capture_if.master        bus,
    output logic [CNT_WIDTH-1:0] frame_width,
    output logic [CNT_WIDTH-1:0] frame_height,
    output logic                 frame_done,
    output logic                 line_err
);
    localparam int unsigned SkipW = $clog2(SKIP_FRAMES + 2);
    localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP_FRAMES == 0 ? 0 : SKIP_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic                vs_r, href_r, vs_rise, vs_fall, href_rise, href_fall;
    logic [IN_WIDTH-1:0] data_r;

    cap_state_e            state_q, state_d;
    logic [SkipW-1:0]      skip_q, skip_d;
    logic                  phase_q, phase_d;
    logic [IN_WIDTH-1:0]   hi_q, hi_d;
    logic [CNT_WIDTH-1:0]  pix_q, pix_d, line_q, line_d, shadow_q, shadow_d;
    logic [CNT_WIDTH-1:0]  width_q, width_d, height_q, height_d;
    logic [CNT_WIDTH-1:0]  line_end, width_end;
    logic                  done_q, done_d, err_q, err_d, en_q, en_d, vs_q, vs_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    dvp_edge_sync #(
        .IN_WIDTH (IN_WIDTH)
    ) u_edge_sync (
        .rgb_clk   (rgb_clk),
        .rgb_rst_n (rgb_rst_n),
        .vsync     (bus.cam_vsync),
        .href      (bus.cam_href),
        .data      (bus.cam_data),
        .vs_r      (vs_r),
        .href_r    (href_r),
        .data_r    (data_r),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .href_rise (href_rise),
        .href_fall (href_fall)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        pix_d     = pix_q;
        line_d    = line_q;
        shadow_d  = shadow_q;
        width_d   = width_q;
        height_d  = height_q;
        out_d     = out_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        en_d      = 1'b0;
        line_end  = line_q;
        width_end = shadow_q;
        // FIFO stays in reset until a whole frame is being captured
        vs_d      = (state_q == StActive) ? vs_r : 1'b1;

        unique case (state_q)
            StSkip: begin
                if (SKIP_FRAMES == 0) begin
                    state_d = StWait;
                end else if (vs_rise) begin
                    if (skip_q == SkipLast) state_d = StWait;
                    else                    skip_d  = skip_q + 1'b1;
                end
            end
            StWait: begin
                if (vs_fall) begin
                    state_d  = StActive;
                    phase_d  = 1'b0;
                    pix_d    = '0;
                    line_d   = '0;
                    shadow_d = '0;
                end
            end
            StActive: begin
                if (href_r) begin
                    // href rising forces phase 0 so a stale half pixel never leaks in
                    if (href_rise || !phase_q) begin
                        hi_d    = data_r;
                        phase_d = 1'b1;
                        if (href_rise) pix_d = '0;
                    end else begin
                        out_d   = {hi_q, data_r};
                        en_d    = 1'b1;
                        pix_d   = sat_inc(pix_q);
                        phase_d = 1'b0;
                    end
                end
                if (href_fall) begin
                    line_end  = sat_inc(line_q);
                    width_end = pix_q;
                    line_d    = line_end;
                    shadow_d  = pix_q;
                    err_d     = phase_q;
                    phase_d   = 1'b0;
                end
                if (vs_rise) begin
                    if (href_r) begin
                        state_d = StWait;
                    end else begin
                        width_d  = width_end;
                        height_d = line_end;
                        done_d   = 1'b1;
                    end
                end
                if (vs_fall) begin
                    pix_d    = '0;
                    line_d   = '0;
                    shadow_d = '0;
                end
            end
            default: state_d = StSkip;
        endcase
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            state_q  <= StSkip;
            skip_q   <= '0;
            phase_q  <= 1'b0;
            hi_q     <= '0;
            pix_q    <= '0;
            line_q   <= '0;
            shadow_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            vs_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            pix_q    <= pix_d;
            line_q   <= line_d;
            shadow_q <= shadow_d;
            width_q  <= width_d;
            height_q <= height_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            vs_q     <= vs_d;
        end
    end

    assign bus.fifo_data_out    = out_q;
    assign bus.fifo_data_out_en = en_q;
    assign bus.fifo_data_vs     = vs_q;
    assign frame_width          = width_q;
    assign frame_height         = height_q;
    assign frame_done           = done_q;
    assign line_err             = err_q;
endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture: two instances (SKIP_FRAMES=2/CNT_WIDTH=12 and
// SKIP_FRAMES=0/CNT_WIDTH=4) share one DVP stimulus; pixels go through queues.
module tb_dvp_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;

    always #5 clk = ~clk;

    dvp_capture_if #(.IN_WIDTH(8), .DATA_WIDTH(16)) if_a ();
    dvp_capture_if #(.IN_WIDTH(8), .DATA_WIDTH(16)) if_b ();

    assign if_a.cam_vsync = cam_vsync;
    assign if_a.cam_href  = cam_href;
    assign if_a.cam_data  = cam_data;
    assign if_b.cam_vsync = cam_vsync;
    assign if_b.cam_href  = cam_href;
    assign if_b.cam_data  = cam_data;

    logic [11:0] fw_a, fh_a;
    logic [3:0]  fw_b, fh_b;
    logic        fd_a, le_a, fd_b, le_b;

    dvp_capture #(
        .DATA_WIDTH  (16),
        .IN_WIDTH    (8),
        .SKIP_FRAMES (2),
        .CNT_WIDTH   (12)
    ) u_dut_a (
        .rgb_clk      (clk),
        .rgb_rst_n    (rst_n),
        .bus          (if_a),
        .frame_width  (fw_a),
        .frame_height (fh_a),
        .frame_done   (fd_a),
        .line_err     (le_a)
    );

    dvp_capture #(
        .DATA_WIDTH  (16),
        .IN_WIDTH    (8),
        .SKIP_FRAMES (0),
        .CNT_WIDTH   (4)
    ) u_dut_b (
        .rgb_clk      (clk),
        .rgb_rst_n    (rst_n),
        .bus          (if_b),
        .frame_width  (fw_b),
        .frame_height (fh_b),
        .frame_done   (fd_b),
        .line_err     (le_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] exp_a, exp_b;
    bit          cap_a = 1'b0;
    bit          cap_b = 1'b0;
    int          strobes_a = 0, strobes_b = 0;
    int          done_a = 0, done_b = 0;
    int          lerr_a = 0, lerr_b = 0;
    bit          vs_low_b = 1'b0;

    // Scoreboard side: every strobe must match the oldest expected pixel
    always @(negedge clk) begin
        if (if_a.fifo_data_out_en === 1'b1) begin
            strobes_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL pixel_a: got unexpected pixel %h, want no strobe",
                         if_a.fifo_data_out);
            end else begin
                exp_a = q_a.pop_front();
                if (if_a.fifo_data_out !== exp_a) begin
                    errors++;
                    $display("FAIL pixel_a: got %h, want %h", if_a.fifo_data_out, exp_a);
                end
            end
        end
        if (if_b.fifo_data_out_en === 1'b1) begin
            strobes_b++;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL pixel_b: got unexpected pixel %h, want no strobe",
                         if_b.fifo_data_out);
            end else begin
                exp_b = q_b.pop_front();
                if (if_b.fifo_data_out !== exp_b) begin
                    errors++;
                    $display("FAIL pixel_b: got %h, want %h", if_b.fifo_data_out, exp_b);
                end
            end
        end
        if (fd_a === 1'b1) done_a++;
        if (fd_b === 1'b1) done_b++;
        if (le_a === 1'b1) lerr_a++;
        if (le_b === 1'b1) lerr_b++;
        if (rst_n && if_b.fifo_data_vs !== 1'b1) vs_low_b = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    task automatic push_pix(input logic [15:0] p);
        if (cap_a) q_a.push_back(p);
        if (cap_b) q_b.push_back(p);
    endtask

    task automatic drive_line(input int nbytes);
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = 8'($urandom);
            if (i % 2 == 0) hi = cam_data;
            else            push_pix({hi, cam_data});
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_frame(input int lines, input int nbytes);
        repeat (lines) drive_line(nbytes);
        vsync_pulse();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if_a.fifo_data_out_en, if_a.fifo_data_out, fd_a, le_a, fw_a, fh_a} !== '0) begin
            errors++;
            $display("FAIL reset_outs_a: got en=%b data=%h w=%0d h=%0d, want all zero",
                     if_a.fifo_data_out_en, if_a.fifo_data_out, fw_a, fh_a);
        end
        checks++;
        if ({if_b.fifo_data_out_en, if_b.fifo_data_out, fd_b, le_b, fw_b, fh_b} !== '0) begin
            errors++;
            $display("FAIL reset_outs_b: got en=%b data=%h w=%0d h=%0d, want all zero",
                     if_b.fifo_data_out_en, if_b.fifo_data_out, fw_b, fh_b);
        end
        checks++;
        if (if_a.fifo_data_vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_vs_a: got %b, want 1", if_a.fifo_data_vs);
        end
        checks++;
        if (if_b.fifo_data_vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_vs_b: got %b, want 1", if_b.fifo_data_vs);
        end
        rst_n = 1'b1;
    endtask

    // Reset leaves the bus mid-frame; A skips two frames, B joins at the next vsync fall
    task automatic test_skip();
        int s_a;
        cap_a = 1'b0;
        cap_b = 1'b0;
        repeat (4) drive_line(8);
        checks++;
        if (strobes_b !== 0) begin
            errors++;
            $display("FAIL midframe_no_en_b: got %0d strobes, want 0", strobes_b);
        end
        checks++;
        if (vs_low_b !== 1'b0) begin
            errors++;
            $display("FAIL midframe_vs_b: got vs low, want held at 1");
        end
        vsync_pulse();
        cap_b = 1'b1;
        drive_frame(4, 8);
        checks++;
        if (strobes_a !== 0 || done_a !== 0) begin
            errors++;
            $display("FAIL skip_a: got %0d strobes %0d done, want 0 and 0", strobes_a, done_a);
        end
        checks++;
        if (done_b !== 1 || fw_b !== 4'd4 || fh_b !== 4'd4) begin
            errors++;
            $display("FAIL frame2_b: got done=%0d w=%0d h=%0d, want 1 4 4", done_b, fw_b, fh_b);
        end
        cap_a = 1'b1;
        s_a = strobes_a;
        drive_frame(4, 8);
        checks++;
        if (strobes_a - s_a !== 16) begin
            errors++;
            $display("FAIL frame3_strobes_a: got %0d, want 16", strobes_a - s_a);
        end
        checks++;
        if (done_a !== 1 || fw_a !== 12'd4 || fh_a !== 12'd4) begin
            errors++;
            $display("FAIL frame3_a: got done=%0d w=%0d h=%0d, want 1 4 4", done_a, fw_a, fh_a);
        end
        checks++;
        if (done_b !== 2 || fw_b !== 4'd4 || fh_b !== 4'd4) begin
            errors++;
            $display("FAIL frame3_b: got done=%0d w=%0d h=%0d, want 2 4 4", done_b, fw_b, fh_b);
        end
    endtask

    // 0x34 is captured by the first posedge after it is driven; _en rises on the second
    task automatic test_latency();
        @(negedge clk);
        cam_href = 1'b1;
        cam_data = 8'h12;
        @(negedge clk);
        cam_data = 8'h34;
        push_pix(16'h1234);
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        checks++;
        if (if_a.fifo_data_out_en !== 1'b0 || if_b.fifo_data_out_en !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got en_a=%b en_b=%b, want 0 0",
                     if_a.fifo_data_out_en, if_b.fifo_data_out_en);
        end
        @(negedge clk);
        checks++;
        if (if_a.fifo_data_out_en !== 1'b1 || if_a.fifo_data_out !== 16'h1234) begin
            errors++;
            $display("FAIL latency_a: got en=%b data=%h, want 1 1234",
                     if_a.fifo_data_out_en, if_a.fifo_data_out);
        end
        checks++;
        if (if_b.fifo_data_out_en !== 1'b1 || if_b.fifo_data_out !== 16'h1234) begin
            errors++;
            $display("FAIL latency_b: got en=%b data=%h, want 1 1234",
                     if_b.fifo_data_out_en, if_b.fifo_data_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_odd_line();
        int s_a, s_b, l_a, l_b;
        s_a = strobes_a;
        s_b = strobes_b;
        l_a = lerr_a;
        l_b = lerr_b;
        drive_line(7);
        checks++;
        if (strobes_a - s_a !== 3 || strobes_b - s_b !== 3) begin
            errors++;
            $display("FAIL odd_strobes: got a=%0d b=%0d, want 3 3", strobes_a - s_a,
                     strobes_b - s_b);
        end
        checks++;
        if (lerr_a - l_a !== 1 || lerr_b - l_b !== 1) begin
            errors++;
            $display("FAIL odd_line_err: got a=%0d b=%0d, want 1 1", lerr_a - l_a, lerr_b - l_b);
        end
        drive_line(8);
        vsync_pulse();
        checks++;
        if (lerr_a - l_a !== 1 || lerr_b - l_b !== 1) begin
            errors++;
            $display("FAIL even_line_err: got a=%0d b=%0d, want 1 1", lerr_a - l_a, lerr_b - l_b);
        end
        checks++;
        if (done_a !== 2 || fw_a !== 12'd4 || fh_a !== 12'd3) begin
            errors++;
            $display("FAIL frame4_a: got done=%0d w=%0d h=%0d, want 2 4 3", done_a, fw_a, fh_a);
        end
        checks++;
        if (done_b !== 3 || fw_b !== 4'd4 || fh_b !== 4'd3) begin
            errors++;
            $display("FAIL frame4_b: got done=%0d w=%0d h=%0d, want 3 4 3", done_b, fw_b, fh_b);
        end
    endtask

    task automatic test_drop();
        logic [7:0] hi;
        int         d_a, d_b;
        hi = 8'h00;
        d_a = done_a;
        d_b = done_b;
        drive_line(6);
        drive_line(6);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = 8'($urandom);
            if (i == 4) cam_vsync = 1'b1;
            if (i < 4) begin
                if (i % 2 == 0) hi = cam_data;
                else            push_pix({hi, cam_data});
            end
        end
        @(negedge clk);
        cam_href = 1'b0;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_a !== d_a || done_b !== d_b) begin
            errors++;
            $display("FAIL drop_done: got a=%0d b=%0d, want %0d %0d", done_a, done_b, d_a, d_b);
        end
        checks++;
        if (fw_a !== 12'd4 || fh_a !== 12'd3 || fw_b !== 4'd4 || fh_b !== 4'd3) begin
            errors++;
            $display("FAIL drop_hold: got a=%0dx%0d b=%0dx%0d, want 4x3 4x3", fw_a, fh_a,
                     fw_b, fh_b);
        end
        drive_frame(3, 6);
        checks++;
        if (done_a !== d_a + 1 || fw_a !== 12'd3 || fh_a !== 12'd3) begin
            errors++;
            $display("FAIL after_drop_a: got done=%0d w=%0d h=%0d, want %0d 3 3", done_a, fw_a,
                     fh_a, d_a + 1);
        end
        checks++;
        if (done_b !== d_b + 1 || fw_b !== 4'd3 || fh_b !== 4'd3) begin
            errors++;
            $display("FAIL after_drop_b: got done=%0d w=%0d h=%0d, want %0d 3 3", done_b, fw_b,
                     fh_b, d_b + 1);
        end
    endtask

    task automatic test_saturate();
        int s_b;
        s_b = strobes_b;
        drive_frame(1, 40);
        checks++;
        if (fw_a !== 12'd20 || fh_a !== 12'd1) begin
            errors++;
            $display("FAIL wide_a: got w=%0d h=%0d, want 20 1", fw_a, fh_a);
        end
        checks++;
        if (fw_b !== 4'd15 || fh_b !== 4'd1) begin
            errors++;
            $display("FAIL saturate_b: got w=%0d h=%0d, want 15 1", fw_b, fh_b);
        end
        checks++;
        if (strobes_b - s_b !== 20) begin
            errors++;
            $display("FAIL saturate_strobes_b: got %0d, want 20", strobes_b - s_b);
        end
    endtask

    task automatic test_drain();
        repeat (5) @(negedge clk);
        checks++;
        if (q_a.size() !== 0 || q_b.size() !== 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending pixels, want 0/0", q_a.size(), q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_latency();
        test_odd_line();
        test_drop();
        test_saturate();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
